// File: rtl/instr_cache_pkg.sv
// Shared sizing constants and fill-state encoding for the instruction-cache fill path.
package instr_cache_pkg;
   localparam int MEM_WIDTH      = 8;
   localparam int INSTR_WIDTH    = 32;
   localparam int CACHE_SIZE     = 256;
   localparam int CNT_WIDTH      = 16;
   localparam int BYTES_PER_WORD = INSTR_WIDTH / MEM_WIDTH;
   localparam int CACHE_BYTES    = BYTES_PER_WORD * CACHE_SIZE;
   localparam int CACHE_ADDR_W   = $clog2(CACHE_BYTES);
   localparam int WORD_OFS_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_e;
endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes little-endian into instruction words; flags the word on its last byte.
module byte_packer
   import instr_cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   byte_valid,
   input  logic [MEM_WIDTH-1:0]   byte_data,
   output logic                   word_valid,
   output logic [INSTR_WIDTH-1:0] word
);
   localparam int LANES_W = INSTR_WIDTH - MEM_WIDTH;

   logic [WORD_OFS_W-1:0] byte_idx_q, byte_idx_d;
   logic [LANES_W-1:0]    lanes_q, lanes_d;
   logic                  last_lane;

   // Earlier bytes shift down so the oldest ends up in the low lane.
   always_comb begin
      last_lane  = (byte_idx_q == WORD_OFS_W'(BYTES_PER_WORD - 1));
      byte_idx_d = byte_idx_q;
      lanes_d    = lanes_q;
      if (clear) begin
         byte_idx_d = '0;
      end else if (byte_valid) begin
         byte_idx_d = last_lane ? '0 : byte_idx_q + WORD_OFS_W'(1);
         lanes_d    = {byte_data, lanes_q[LANES_W-1:MEM_WIDTH]};
      end
   end

   assign word_valid = byte_valid && !clear && last_lane;
   assign word       = {byte_data, lanes_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx_q <= '0;
         lanes_q    <= '0;
      end else begin
         byte_idx_q <= byte_idx_d;
         lanes_q    <= lanes_d;
      end
   end
endmodule

// File: rtl/instr_cache_fill.sv
// Streams bytes into the instruction cache as packed words at a running, wrapping byte address.
// Optional running word checksum enabled by defining INSTR_FILL_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting bytes, one cache write per packed word
// DONE  | one-cycle completion pulse, then back to IDLE
module instr_cache_fill
   import instr_cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [INSTR_WIDTH-1:0] baseAddr,
   input  logic [CNT_WIDTH-1:0]   wordCount,
   input  logic                   abort,
   input  logic [MEM_WIDTH-1:0]   memData,
   input  logic                   memValid,
   output logic                   memReady,
   output logic                   wrEn,
   output logic [INSTR_WIDTH-1:0] wrAddr,
   output logic [INSTR_WIDTH-1:0] wrData,
   output logic                   busy,
   output logic                   done,
   output logic [INSTR_WIDTH-1:0] checksum
);
   fill_state_e             state_q, state_d;
   logic [CACHE_ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
   logic                    wr_en_q, wr_en_d;
   logic [INSTR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [INSTR_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pack_clear;
   logic                    word_valid;
   logic [INSTR_WIDTH-1:0]  word;
   logic                    unused_base_bits;

   // Only the in-cache, word-aligned address bits matter.
   assign unused_base_bits = ^{baseAddr[INSTR_WIDTH-1:CACHE_ADDR_W], baseAddr[WORD_OFS_W-1:0]};

   assign memReady = (state_q == FILL);

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pack_clear),
      .byte_valid (memValid && memReady),
      .byte_data  (memData),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      pack_clear  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               pack_clear = 1'b1;
               if (wordCount != '0) begin
                  addr_d      = {baseAddr[CACHE_ADDR_W-1:WORD_OFS_W], WORD_OFS_W'(0)};
                  remaining_d = wordCount;
                  state_d     = FILL;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FILL: begin
            // Abort takes priority over a word completing in the same cycle.
            if (abort) begin
               pack_clear = 1'b1;
               state_d    = IDLE;
            end else if (word_valid) begin
               wr_en_d     = 1'b1;
               wr_addr_d   = INSTR_WIDTH'(addr_q);
               wr_data_d   = word;
               addr_d      = addr_q + CACHE_ADDR_W'(BYTES_PER_WORD);
               remaining_d = remaining_q - CNT_WIDTH'(1);
               if (remaining_q == CNT_WIDTH'(1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign wrEn   = wr_en_q;
   assign wrAddr = wr_addr_q;
   assign wrData = wr_data_q;
   assign busy   = busy_q;
   assign done   = done_q;

`ifdef INSTR_FILL_CHECKSUM_EN
   logic [INSTR_WIDTH-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (state_q == IDLE && start) checksum_d = '0;
      else if (wr_en_d)             checksum_d = checksum_q + wr_data_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) checksum_q <= '0;
      else     checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_cache_fill.sv
// Scoreboard bench for instr_cache_fill: expected writes queued at stimulus time, popped on wrEn.
module tb_instr_cache_fill;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] baseAddr = '0;
   logic [15:0] wordCount = '0;
   logic        abort = 1'b0;
   logic [7:0]  memData = '0;
   logic        memValid = 1'b0;
   logic        memReady, wrEn, busy, done;
   logic [31:0] wrAddr, wrData, checksum;

`ifdef INSTR_FILL_CHECKSUM_EN
   localparam bit CKSUM_ON = 1'b1;
`else
   localparam bit CKSUM_ON = 1'b0;
`endif

   instr_cache_fill dut (
      .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .wordCount(wordCount),
      .abort(abort), .memData(memData), .memValid(memValid), .memReady(memReady),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .busy(busy), .done(done),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   int          wr_cycles[$];
   int          done_cycles[$];
   logic [31:0] model_sum = '0;
   logic [31:0] mon_a, mon_d, exp_ck;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (wrEn) begin
            wr_cycles.push_back(cyc);
            tests_run++;
            if (exp_addr_q.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_wr: got addr %h data %h, expected no write", wrAddr, wrData);
            end else begin
               mon_a = exp_addr_q.pop_front();
               mon_d = exp_data_q.pop_front();
               model_sum = model_sum + mon_d;
               if (wrAddr !== mon_a || wrData !== mon_d) begin
                  tests_failed++;
                  $display("FAIL wr_word: got addr %h data %h, expected addr %h data %h",
                           wrAddr, wrData, mon_a, mon_d);
               end
            end
         end
         if (done) begin
            done_cycles.push_back(cyc);
            exp_ck = CKSUM_ON ? model_sum : 32'h0;
            tests_run++;
            if (checksum !== exp_ck) begin
               tests_failed++;
               $display("FAIL checksum_at_done: got %h expected %h", checksum, exp_ck);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests_run %0d", tests_run);
      $fatal(1, "watchdog");
   end

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
   endtask

   task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
      model_sum = '0;
      wr_cycles.delete();
      done_cycles.delete();
      start = 1'b1; baseAddr = base; wordCount = cnt;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      memData = b; memValid = 1'b1;
      forever begin
         @(negedge clk);
         if (memReady) break;
         n++;
         if (n > 50) break;
      end
      if (n > 50) begin
         tests_run++; tests_failed++;
         $display("FAIL byte_timeout: memReady 0 for %0d cycles, expected 1", n);
         memValid = 1'b0;
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         memValid = 1'b0;
      end
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic wait_idle();
      int n = 0;
      forever begin
         @(negedge clk);
         if (!busy || n > 100) break;
         n++;
      end
      tests_run++;
      if (busy) begin
         tests_failed++;
         $display("FAIL idle_timeout: busy %b after %0d cycles, expected 0", busy, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_counts(input string name, input int n_wr, input int n_done);
      tests_run++;
      if (wr_cycles.size() != n_wr || done_cycles.size() != n_done) begin
         tests_failed++;
         $display("FAIL %s_counts: got %0d writes %0d done, expected %0d writes %0d done",
                  name, wr_cycles.size(), done_cycles.size(), n_wr, n_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({memReady, wrEn, busy, done} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got ready/wr/busy/done %b, expected 0000", {memReady, wrEn, busy, done});
      end
      tests_run++;
      if (wrAddr !== 32'h0 || wrData !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_wr: got addr %h data %h, expected 0 0", wrAddr, wrData);
      end
      tests_run++;
      if (checksum !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_checksum: got %h expected 0", checksum);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      expect_wr(32'h10, 32'h44332211);
      expect_wr(32'h14, 32'h88776655);
      do_start(32'h10, 16'd2);
      send_word(32'h44332211, 0);
      send_word(32'h88776655, 0);
      wait_idle();
      check_counts("basic", 2, 1);
      tests_run++;
      if (wr_cycles.size() != 2 || wr_cycles[0] != start_cyc + 4 || wr_cycles[1] != start_cyc + 8) begin
         tests_failed++;
         $display("FAIL basic_wr_timing: got %0d writes, first offset %0d, expected offsets 4 and 8",
                  wr_cycles.size(), (wr_cycles.size() > 0) ? wr_cycles[0] - start_cyc : -1);
      end
      tests_run++;
      if (done_cycles.size() != 1 || done_cycles[0] != start_cyc + 8) begin
         tests_failed++;
         $display("FAIL basic_done_timing: got %0d done pulses, first offset %0d, expected offset 8",
                  done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] - start_cyc : -1);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      exp_ck = CKSUM_ON ? 32'hCCAA8866 : 32'h0;
      tests_run++;
      if (checksum !== exp_ck) begin
         tests_failed++;
         $display("FAIL basic_checksum_hold: got %h expected %h", checksum, exp_ck);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      expect_wr(32'h10, 32'h44332211);
      expect_wr(32'h14, 32'h88776655);
      do_start(32'h10, 16'd2);
      send_word(32'h44332211, 3);
      send_word(32'h88776655, 3);
      wait_idle();
      check_counts("stall", 2, 1);
      tests_run++;
      if (wr_cycles.size() != 2 || wr_cycles[0] != start_cyc + 13 || wr_cycles[1] != start_cyc + 29) begin
         tests_failed++;
         $display("FAIL stall_wr_timing: got %0d writes, first offset %0d, expected offsets 13 and 29",
                  wr_cycles.size(), (wr_cycles.size() > 0) ? wr_cycles[0] - start_cyc : -1);
      end
   endtask

   task automatic test_wrap();
      expect_wr(32'h3FC, 32'hA3A2A1A0);
      expect_wr(32'h000, 32'hB3B2B1B0);
      do_start(32'h3FE, 16'd2);
      send_word(32'hA3A2A1A0, 0);
      send_word(32'hB3B2B1B0, 0);
      wait_idle();
      check_counts("wrap", 2, 1);
   endtask

   task automatic test_abort();
      expect_wr(32'h100, 32'h0D0C0B0A);
      do_start(32'h100, 16'd3);
      send_word(32'h0D0C0B0A, 0);
      send_byte(8'h1A, 0);
      send_byte(8'h1B, 0);
      memData = 8'h1C; memValid = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; memValid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || memReady !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_idle: got busy %b ready %b, expected 0 0", busy, memReady);
      end
      repeat (4) @(posedge clk);
      #1;
      check_counts("abort", 1, 0);

      // abort coinciding with the last byte of a word suppresses the write
      do_start(32'h200, 16'd1);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      memData = 8'h04; memValid = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; memValid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_counts("abort_last_byte", 0, 0);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_last_busy: got %b expected 0", busy);
      end

      expect_wr(32'h20, 32'h78563412);
      do_start(32'h20, 16'd1);
      send_word(32'h78563412, 0);
      wait_idle();
      check_counts("after_abort", 1, 1);
      tests_run++;
      if (done_cycles.size() != 1 || done_cycles[0] != start_cyc + 4) begin
         tests_failed++;
         $display("FAIL after_abort_done: got %0d pulses, expected one at offset 4", done_cycles.size());
      end
   endtask

   task automatic test_zero_count();
      do_start(32'h50, 16'd0);
      @(negedge clk);
      tests_run++;
      if ({done, busy, memReady} !== 3'b110) begin
         tests_failed++;
         $display("FAIL zero_done: got done/busy/ready %b expected 110", {done, busy, memReady});
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if ({done, busy, memReady} !== 3'b000) begin
         tests_failed++;
         $display("FAIL zero_after: got done/busy/ready %b expected 000", {done, busy, memReady});
      end
      @(posedge clk); #1;
      check_counts("zero", 0, 1);
   endtask

   task automatic test_start_in_fill();
      expect_wr(32'h40, 32'h11223344);
      expect_wr(32'h44, 32'h55667788);
      do_start(32'h40, 16'd2);
      send_byte(8'h44, 0);
      send_byte(8'h33, 0);
      start = 1'b1; baseAddr = 32'h80; wordCount = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      send_byte(8'h22, 0);
      send_byte(8'h11, 0);
      send_word(32'h55667788, 0);
      wait_idle();
      check_counts("start_in_fill", 2, 1);
   endtask

   task automatic test_checksum();
      expect_wr(32'h300, 32'h00000001);
      expect_wr(32'h304, 32'hFFFFFFFF);
      do_start(32'h300, 16'd2);
      send_word(32'h00000001, 0);
      send_word(32'hFFFFFFFF, 0);
      wait_idle();
      check_counts("checksum", 2, 1);
      tests_run++;
      if (checksum !== 32'h0) begin
         tests_failed++;
         $display("FAIL checksum_wrap: got %h expected 00000000", checksum);
      end
   endtask

   task automatic test_rst_mid_fill();
      do_start(32'h60, 16'd2);
      send_byte(8'hEE, 0);
      send_byte(8'hDD, 0);
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({busy, memReady, wrEn, done} !== 4'b0000 || wrAddr !== 32'h0 || wrData !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_mid: got busy/ready/wr/done %b addr %h data %h, expected 0000 0 0",
                  {busy, memReady, wrEn, done}, wrAddr, wrData);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      expect_wr(32'h70, 32'hCAFEF00D);
      do_start(32'h70, 16'd1);
      send_word(32'hCAFEF00D, 0);
      wait_idle();
      check_counts("after_rst", 1, 1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_abort();
      test_zero_count();
      test_start_in_fill();
      test_checksum();
      test_rst_mid_fill();
      tests_run++;
      if (exp_addr_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", exp_addr_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
